level_speed_ctrl: RTL

//  Upstream stage of frame_clk_generator: turns line-clear events from the board logic into

---
 rtl/level_speed_ctrl.sv | 136 +++++++++++++
 1 files changed

// File: rtl/level_speed_ctrl.sv
// Turns line-clear events into Lines_Total/Level/Score and the Fall_Count gravity setting for frame_clk_generator.
// Optional Soft_Drop input (fast fixed Fall_Count) is built only when SOFT_DROP_EN is defined.
module level_speed_ctrl #(
  parameter int LINES_PER_LEVEL = 10,
  parameter int LEVEL_MAX       = 20,
  parameter int FALL_STEP       = 4,
  parameter int FALL_MAX        = 70
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Game_Start,
  input  logic        Game_Over,
  input  logic        Lines_Valid,
  input  logic [2:0]  Lines_Cleared,
`ifdef SOFT_DROP_EN
  input  logic        Soft_Drop,
`endif
  output logic        Lines_Ready,
  output logic [4:0]  Level,
  output logic [9:0]  Lines_Total,
  output logic [19:0] Score,
  output logic [6:0]  Fall_Count,
  output logic        Level_Up
);

  typedef enum logic [1:0] {IDLE, RUN, SCORE} state_t;

  state_t      state;
  logic [3:0]  lines_in_level;
  logic [10:0] base;
  logic [4:0]  mult;

  logic [2:0]  n_clamp;
  logic        accept;
  logic [10:0] base_lut;
  logic [4:0]  lil_sum;
  logic [10:0] total_sum;
  logic [9:0]  total_next;
  logic [20:0] score_sum;
  logic [19:0] score_next;
  logic [9:0]  fall_raw;
  logic [6:0]  fall_lvl;
  logic [6:0]  fall_next;

  assign Lines_Ready = (state == RUN);
  assign n_clamp     = (Lines_Cleared > 3'd4) ? 3'd4 : Lines_Cleared;
  assign accept      = Lines_Valid & Lines_Ready;

  always_comb begin
    base_lut = 11'd0;
    case (n_clamp)
      3'd0:    base_lut = 11'd0;
      3'd1:    base_lut = 11'd40;
      3'd2:    base_lut = 11'd100;
      3'd3:    base_lut = 11'd300;
      default: base_lut = 11'd1200;
    endcase
  end

  // All sums are one bit wider than the register they feed, then clipped.
  assign lil_sum    = {1'b0, lines_in_level} + {2'b00, n_clamp};
  assign total_sum  = {1'b0, Lines_Total} + {8'd0, n_clamp};
  assign total_next = (total_sum > 11'd999) ? 10'd999 : total_sum[9:0];
  assign score_sum  = {1'b0, Score} + {10'd0, base};
  assign score_next = (score_sum > 21'd999999) ? 20'd999999 : score_sum[19:0];
  assign fall_raw   = {5'd0, Level} * 10'(FALL_STEP);
  assign fall_lvl   = (fall_raw > 10'(FALL_MAX)) ? 7'(FALL_MAX) : fall_raw[6:0];

`ifdef SOFT_DROP_EN
  assign fall_next = (Soft_Drop && state != IDLE) ? 7'd127 : fall_lvl;
`else
  assign fall_next = fall_lvl;
`endif

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state          <= IDLE;
      Level          <= 5'd0;
      Lines_Total    <= 10'd0;
      Score          <= 20'd0;
      Fall_Count     <= 7'd0;
      Level_Up       <= 1'b0;
      lines_in_level <= 4'd0;
      base           <= 11'd0;
      mult           <= 5'd0;
    end else begin
      Level_Up   <= 1'b0;
      Fall_Count <= fall_next;
      if (Game_Start) begin
        state          <= RUN;
        Level          <= 5'd0;
        Lines_Total    <= 10'd0;
        Score          <= 20'd0;
        Fall_Count     <= 7'd0;
        lines_in_level <= 4'd0;
        base           <= 11'd0;
        mult           <= 5'd0;
      end else begin
        case (state)
          IDLE: state <= IDLE;
          RUN: begin
            if (Game_Over) begin
              state <= IDLE;
            end else if (accept) begin
              Lines_Total <= total_next;
              base        <= base_lut;
              mult        <= Level + 5'd1;
              if (lil_sum >= 5'(LINES_PER_LEVEL)) begin
                lines_in_level <= 4'(lil_sum - 5'(LINES_PER_LEVEL));
                if (Level < 5'(LEVEL_MAX)) begin
                  Level    <= Level + 5'd1;
                  Level_Up <= 1'b1;
                end
              end else begin
                lines_in_level <= lil_sum[3:0];
              end
              if (n_clamp != 3'd0) state <= SCORE;
            end
          end
          SCORE: begin
            // One add of base per cycle; mult holds the remaining adds including this one.
            if (Game_Over) begin
              state <= IDLE;
            end else begin
              Score <= score_next;
              mult  <= mult - 5'd1;
              if (mult == 5'd1) state <= RUN;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
